// File: rtl/video_decoder.sv
// Receive side of the composite video link: separates sync pulses by width,
// recovers line/frame timing and pixel coordinates, and flags drawing-area samples.
module video_decoder #(
    parameter int unsigned HSYNC_MIN      = 64,
    parameter int unsigned VSYNC_MIN      = 512,
    parameter int unsigned LINE_TIMEOUT   = 4000,
    parameter int unsigned ACTIVE_X_START = 256,
    parameter int unsigned ACTIVE_WIDTH   = 1536,
    parameter int unsigned ACTIVE_Y_START = 33,
    parameter int unsigned ACTIVE_HEIGHT  = 200
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sync,
    input  logic        luminance,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] x,
    output logic [8:0]  y,
    output logic        pixel,
    output logic        pixel_valid
);

    localparam int unsigned XW  = 12;
    localparam int unsigned YW  = 9;
    localparam int unsigned CW  = 12;
    localparam int unsigned XW1 = XW + 1;
    localparam int unsigned YW1 = YW + 1;

    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [CW-1:0]  H_MIN   = CW'(HSYNC_MIN);
    localparam logic [CW-1:0]  V_MIN   = CW'(VSYNC_MIN);
    localparam logic [XW-1:0]  X_MAX   = XW'(LINE_TIMEOUT);
    localparam logic [YW-1:0]  Y_MAX   = '1;
    localparam logic [XW1-1:0] X_LO    = XW1'(ACTIVE_X_START);
    localparam logic [XW1-1:0] X_HI    = XW1'(ACTIVE_X_START + ACTIVE_WIDTH);
    localparam logic [YW1-1:0] Y_LO    = YW1'(ACTIVE_Y_START);
    localparam logic [YW1-1:0] Y_HI    = YW1'(ACTIVE_Y_START + ACTIVE_HEIGHT);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t         state, state_nxt;
    logic           sync_s1, sync_s2, sync_d;
    logic           lum_s1, lum_s2;
    logic [CW-1:0]  low_count;
    logic           in_vsync;
    logic           rise, is_h, is_v, accept, fs_set;
    logic [XW-1:0]  x_nxt;

    // Pulse classification on the rising edge of the synchronized sync line
    always_comb begin
        rise   = sync_s2 & ~sync_d;
        is_h   = rise && (low_count >= H_MIN) && (low_count < V_MIN);
        is_v   = rise && (low_count >= V_MIN);
        accept = is_h | is_v;
        fs_set = is_v & ~in_vsync;
        if (accept)
            x_nxt = '0;
        else if (x >= X_MAX)
            x_nxt = X_MAX;
        else
            x_nxt = x + XW'(1);
    end

    // Lock state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    // Lock next-state: a sync rise always beats the timeout since it zeroes x_nxt
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (fs_set) state_nxt = LOCKED;
            LOCKED: if (x_nxt == X_MAX) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    // Input synchronizers, width counter and timing datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1     <= 1'b1;
            sync_s2     <= 1'b1;
            sync_d      <= 1'b1;
            lum_s1      <= 1'b0;
            lum_s2      <= 1'b0;
            pixel       <= 1'b0;
            low_count   <= '0;
            x           <= '0;
            y           <= '0;
            in_vsync    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync_s1     <= sync;
            sync_s2     <= sync_s1;
            sync_d      <= sync_s2;
            lum_s1      <= luminance;
            lum_s2      <= lum_s1;
            pixel       <= lum_s2;
            if (sync_s2)
                low_count <= '0;
            else if (low_count != CNT_MAX)
                low_count <= low_count + CW'(1);
            x           <= x_nxt;
            line_start  <= is_h;
            frame_start <= fs_set;
            if (is_h) begin
                if (y != Y_MAX)
                    y <= y + YW'(1);
                in_vsync <= 1'b0;
            end else if (is_v) begin
                y        <= '0;
                in_vsync <= 1'b1;
            end
        end
    end

    assign locked = (state == LOCKED);

    assign pixel_valid = locked
                      && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
                      && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

endmodule

// File: tb/tb_video_decoder.sv
// Scoreboard bench for video_decoder: random and directed sync pulse trains checked
// against a pulse-width/timing reference model.
module tb_video_decoder;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        sync      = 1'b1;
    logic        luminance = 1'b0;
    logic        line_start, frame_start, locked, pixel, pixel_valid;
    logic [11:0] x;
    logic [8:0]  y;

    video_decoder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sync        (sync),
        .luminance   (luminance),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .x           (x),
        .y           (y),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    always #5 clock = ~clock;

    // kind: 0 = line_start, 1 = frame_start, 2 = vertical pulse with no output pulse
    typedef struct {
        int t;
        int kind;
        int y;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         cmp = 0;
    int         fail = 0;
    int         dy = 0;
    bit         dvs = 1'b0;
    int         base = 0;
    int         my = 0;
    bit         mlocked = 1'b0;
    logic [2:0] lh = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // luminance history: pixel follows the pin by three clock edges
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) lh <= '0;
        else          lh <= {lh[1:0], luminance};
    end

    // Reference model of one sync rise given the low width in clocks
    task automatic model_rise(input int low);
        ev_t e;
        if (low < 64) return;
        e.t = cyc + 3;
        if (low < 512) begin
            dy     = (dy >= 511) ? 511 : dy + 1;
            dvs    = 1'b0;
            e.kind = 0;
            e.y    = dy;
        end else begin
            e.kind = dvs ? 2 : 1;
            dy     = 0;
            dvs    = 1'b1;
            e.y    = 0;
        end
        q.push_back(e);
    endtask

    task automatic pulse(input int low, input int high);
        sync = 1'b0;
        repeat (low) @(posedge clock);
        #1 sync = 1'b1;
        model_rise(low);
        repeat (high) @(posedge clock);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        sync    = 1'b1;
        dy      = 0;
        dvs     = 1'b0;
        repeat (n) @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic void apply(input ev_t e);
        base = e.t;
        my   = e.y;
        if (e.kind == 1) mlocked = 1'b1;
    endfunction

    initial forever begin
        @(posedge clock);
        #1 luminance = 1'($urandom);
    end

    // Monitor: pops an expected event whenever the DUT pulses, checks timing every cycle
    initial begin
        ev_t mon_e;
        int  ex;
        bit  epv;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cmp++;
                if (x != 0 || y != 0 || locked || line_start || frame_start || pixel || pixel_valid) begin
                    fail++;
                    $display("FAIL reset_state: x=%0d y=%0d locked=%b ls=%b fs=%b pixel=%b pv=%b, expected all 0",
                             x, y, locked, line_start, frame_start, pixel, pixel_valid);
                end
                base    = cyc;
                my      = 0;
                mlocked = 1'b0;
                q.delete();
            end else begin
                if (q.size() > 0 && q[0].kind == 2 && q[0].t <= cyc) begin
                    mon_e = q.pop_front();
                    apply(mon_e);
                end
                if (q.size() > 0 && q[0].kind != 2 && q[0].t < cyc) begin
                    cmp++;
                    fail++;
                    mon_e = q.pop_front();
                    $display("FAIL missed_pulse: no pulse observed by cycle %0d, expected kind=%0d y=%0d at cycle %0d",
                             cyc, mon_e.kind, mon_e.y, mon_e.t);
                    apply(mon_e);
                end
                if (line_start || frame_start) begin
                    cmp++;
                    if (q.size() == 0 || q[0].kind == 2 || q[0].t > cyc) begin
                        fail++;
                        $display("FAIL spurious_pulse: ls=%b fs=%b at cycle %0d, expected no pulse",
                                 line_start, frame_start, cyc);
                    end else begin
                        mon_e = q.pop_front();
                        if (mon_e.t != cyc || line_start != (mon_e.kind == 0) ||
                            frame_start != (mon_e.kind == 1) || y != 9'(mon_e.y)) begin
                            fail++;
                            $display("FAIL pulse: cycle=%0d ls=%b fs=%b y=%0d, expected cycle=%0d kind=%0d y=%0d",
                                     cyc, line_start, frame_start, y, mon_e.t, mon_e.kind, mon_e.y);
                        end
                        apply(mon_e);
                    end
                end
                ex = cyc - base;
                if (ex > 4000) ex = 4000;
                if (ex == 4000) mlocked = 1'b0;
                epv = mlocked && ex >= 256 && ex < 1792 && my >= 33 && my < 233;
                cmp++;
                if (x != 12'(ex) || y != 9'(my) || locked != mlocked || pixel_valid != epv || pixel != lh[2]) begin
                    fail++;
                    $display("FAIL cycle_state @%0d: x=%0d y=%0d locked=%b pv=%b pixel=%b, expected x=%0d y=%0d locked=%b pv=%b pixel=%b",
                             cyc, x, y, locked, pixel_valid, pixel, ex, my, mlocked, epv, lh[2]);
                end
            end
        end
    end

    initial begin
        int bvals[4];
        int c;
        int low;
        bvals = '{63, 64, 511, 512};

        // reset with sync toggling, then idle release
        reset_n = 1'b0;
        repeat (20) begin
            @(posedge clock);
            #1 sync = 1'($urandom);
        end
        do_reset(3);
        hold(50);

        // single horizontal pulse, glitch, vsync group with serrations, lines
        pulse(150, 200);
        pulse(40, 300);
        repeat (3) pulse(900, 116);
        repeat (3) pulse(150, 1882);

        // random pulse train including width boundaries and timeouts
        for (int i = 0; i < 24; i++) begin
            c = $urandom_range(0, 3);
            case (c)
                0:       low = $urandom_range(1, 63);
                1:       low = $urandom_range(64, 511);
                2:       low = $urandom_range(512, 1000);
                default: low = bvals[$urandom_range(0, 3)];
            endcase
            pulse(low, $urandom_range(8, 1200));
        end

        // structured frame exercising the drawing-area edges
        pulse(150, 50);
        repeat (3) pulse(900, 116);
        repeat (31) pulse(64, 10);
        repeat (3) pulse(150, 1900);
        repeat (197) pulse(64, 10);
        repeat (3) pulse(150, 1900);

        // lock loss on timeout, relock, reset mid-line
        hold(4200);
        pulse(900, 100);
        pulse(150, 300);
        do_reset(2);
        pulse(150, 100);
        hold(20);

        cmp++;
        if (q.size() != 0) begin
            fail++;
            $display("FAIL pending_events: %0d left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", cmp, fail);
        $finish;
    end

endmodule
